temp_to_celsius: RTL
====================

// Module: temp_to_celsius
// PURPOSE
//  Inverse of the C->C/F/K temperature converter. It accepts a reading in Celsius, Fahrenheit
//  or Kelvin (board scale) and returns Celsius.
//  - Operand capture uses ld/st, the same controls as the forward path.
//  - F->C runs on a multi-cycle restoring divider; C->C and K->C are short-path.
//  - Drives the same 8-bit LED format as the forward converter for board self-check.
// PARAMETERS
//  W          4   data width of X and C_out
//  GT_THRESH  10  LED[7] lights when C_out > GT_THRESH
// PORTS
//  clk     in   1  system clock, rising edge
//  clr_n   in   1  reset, asynchronous, active-low
//  X       in   W  input temperature in source scale
//  sel     in   2  source scale: 00 C, 01 F, 10 K, 11 invalid
//  ld      in   1  capture X/sel into operand regs (IDLE only)
//  st      in   1  start conversion (IDLE only)
//  C_out   out  W  Celsius result, held until next DONE
//  busy    out  1  1 in PREP/CALC/DONE
//  done    out  1  1-cycle pulse, result valid
//  err     out  1  underflow or invalid sel, held with C_out
//  sat     out  1  result clipped to 2^W-1, held with C_out
//  LED     out  8  [2:0] one-hot captured sel (000 for 11); [6:3] C_out[3:0]; [7] C_out>GT_THRESH
// BEHAVIOUR
//  Reset (clr_n=0, async, any state, incl. mid-CALC):
//  - state=IDLE; operand regs=0.
//  - C_out, busy, done, err, sat=0; LED=8'h00.
//  - No done is produced for an aborted conversion.
//  Conversion scale rules:
//  - Forward mapping is K=C+3, F=floor(C*5/8)+2.
//  - Inverse: C->C: C=X. K->C: C=X-3. F->C: C=floor(((X-2)*8)/5).
//  - Intermediate width is W+3 bits.
//  Error and saturation:
//  - Underflow (K: X<3; F: X<2) or sel=11: C_out=0, err=1, sat=0.
//  - Result >2^W-1: C_out=2^W-1, sat=1.
//  Handshake:
//  - ld in IDLE captures X and sel. ld outside IDLE is ignored.
//  - st in IDLE starts a conversion. st outside IDLE is ignored (not queued).
//  - ld and st high in the same IDLE cycle: the conversion uses the X/sel being loaded (bypass).
//  FSM:
//  - IDLE -st-> PREP.
//  - PREP: subtract offset, check underflow and sel, load divider.
//    -> CALC if F and no error; else -> DONE.
//  - CALC: W+3 cycles, one quotient bit per cycle (restoring divide by 5) -> DONE.
//  - DONE: C_out/err/sat update at the entry edge; done=1 for exactly this cycle -> IDLE.
//  Latency (accepting st edge = cycle 0):
//  - done high in cycle 2 for C/K/error.
//  - done high in cycle W+5 for F (cycle 9 at W=4).
//  - Back-to-back: st in the first IDLE cycle after DONE is accepted.
//  LED:
//  - Registered; updates with C_out. LED[2:0] updates on ld.
// STRUCTURE
//  temp_conv_pkg (shared with forward converter):
//  - scale_e {SC_C, SC_F, SC_K, SC_INV}
//  - K_OFS=3, F_OFS=2, F_NUM=8, F_DEN=5
//  - conv_state_e {IDLE, PREP, CALC, DONE}
//  Sub-module temp_div_const:
//  - Restoring divider by F_DEN, W+3-bit dividend.
//  - load/step/quot ports; iteration count supplied by the top FSM.
//  Top: operand regs, FSM, offset/underflow logic, saturation, LED encoder.
// TESTING
//  1 K->C: ld+st, X=9, sel=10 -> done in cycle 2; C_out=6, err=0; LED=8'b0011_0100.
//  2 F->C: ld X=7, sel=01; st -> busy cycles 1..9, done in cycle 9; C_out=8 (X=4 -> C_out=3).
//  3 F->C saturation: X=15, sel=01 -> C_out=15, sat=1, LED[7]=1, done in cycle 9.
//  4 Underflow/invalid: K X=2 -> err=1, C_out=0, done in cycle 2; sel=11 -> err=1, LED[2:0]=000.
//  5 Handshake: st and ld (X=3) pulsed during CALC -> ignored, result unchanged; ld+st same cycle uses new X.
//  6 Reset mid-CALC: clr_n=0 at cycle 4 -> all outputs 0 immediately; no done; next st converts normally.

Source files
------------

// File: rtl/temp_conv_pkg.sv
// ---------------------------------------------------------------------------
// temp_conv_pkg
// Shared definitions for the temperature converters. The forward converter
// (C -> C/F/K) uses this package, and so does the inverse converter
// temp_to_celsius.
//   scale_e      : source/target scale encoding, which matches the 2-bit sel input
//   conv_state_e : converter FSM states
//   K_OFS/F_OFS  : additive offsets of the board K and F scales
//   F_NUM/F_DEN  : F scale ratio (C = (F - F_OFS) * F_NUM / F_DEN)
//   sel_onehot   : LED[2:0] encoding of a scale (invalid scale gives 000)
// ---------------------------------------------------------------------------
package temp_conv_pkg;

   typedef enum logic [1:0] {
      SC_C   = 2'b00,
      SC_F   = 2'b01,
      SC_K   = 2'b10,
      SC_INV = 2'b11
   } scale_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      PREP = 2'b01,
      CALC = 2'b10,
      DONE = 2'b11
   } conv_state_e;

   localparam int K_OFS = 3;
   localparam int F_OFS = 2;
   localparam int F_NUM = 8;
   localparam int F_DEN = 5;

   function automatic logic [2:0] sel_onehot(input scale_e s);
      logic [2:0] oh;
      oh = 3'b000;
      case (s)
         SC_C:    oh = 3'b001;
         SC_F:    oh = 3'b010;
         SC_K:    oh = 3'b100;
         default: oh = 3'b000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/temp_to_celsius_if.sv
// ---------------------------------------------------------------------------
// temp_to_celsius_if
// Operand/result bundle of the inverse temperature converter.
//   X      : input temperature in source scale (W bits)
//   sel    : source scale (00 C, 01 F, 10 K, 11 invalid)
//   ld, st : operand capture / start conversion
//   C_out  : Celsius result (W bits), plus busy/done/err/sat status
//   LED    : 8-bit board self-check display
// master drives the operands, and slave (the converter) drives the results.
// ---------------------------------------------------------------------------
interface temp_to_celsius_if #(
   parameter int W = 4
);

   logic [W-1:0] X;
   logic [1:0]   sel;
   logic         ld;
   logic         st;
   logic [W-1:0] C_out;
   logic         busy;
   logic         done;
   logic         err;
   logic         sat;
   logic [7:0]   LED;

   modport master (
      output X, sel, ld, st,
      input  C_out, busy, done, err, sat, LED
   );

   modport slave (
      input  X, sel, ld, st,
      output C_out, busy, done, err, sat, LED
   );

endinterface

// File: rtl/temp_div_const.sv
// ---------------------------------------------------------------------------
// temp_div_const
// Restoring divider by the constant F_DEN. It produces one quotient bit per step.
//   clk, clr_n : clock, asynchronous active-low reset
//   load       : capture dividend and clear the partial remainder
//   dividend   : DW-bit dividend
//   step       : perform one restoring iteration
//   quot       : quotient register value after the current step, so that the
//                final step's result is visible on the edge that performs it
// The caller decides how many steps to run (DW steps give the full quotient).
// ---------------------------------------------------------------------------
module temp_div_const
   import temp_conv_pkg::*;
#(
   parameter int DW = 7
) (
   input  logic          clk,
   input  logic          clr_n,
   input  logic          load,
   input  logic [DW-1:0] dividend,
   input  logic          step,
   output logic [DW-1:0] quot
);

   // The remainder stays below F_DEN. The trial value 2*rem+1 needs one more bit.
   localparam int RW = $clog2(2 * F_DEN);

   logic [RW-1:0] rem_q;
   logic [RW-1:0] rem_nxt;
   logic [RW-1:0] trial;
   logic          fits;
   logic [DW-1:0] dvd_q;

   // Shift the next dividend bit into the remainder. Then subtract the divisor
   // only when it fits. The dividend register fills with quotient bits from
   // the right as its own bits shift out.
   always_comb begin
      trial   = {rem_q[RW-2:0], dvd_q[DW-1]};
      fits    = (trial >= RW'(F_DEN));
      rem_nxt = fits ? (trial - RW'(F_DEN)) : trial;
      quot    = {dvd_q[DW-2:0], fits};
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         rem_q <= '0;
         dvd_q <= '0;
      end else if (load) begin
         rem_q <= '0;
         dvd_q <= dividend;
      end else if (step) begin
         rem_q <= rem_nxt;
         dvd_q <= quot;
      end
   end

endmodule

// File: rtl/temp_to_celsius.sv
// ---------------------------------------------------------------------------
// temp_to_celsius
// Converts a board-scale C, F or K reading to Celsius. C and K take the short
// path through PREP. F runs W+3 cycles on the restoring divider.
//   clk   : system clock, rising edge
//   clr_n : asynchronous active-low reset
//   bus   : temp_to_celsius_if.slave (X, sel, ld, st in; C_out, busy, done,
//           err, sat, LED out)
// Parameters: W data width; GT_THRESH is the threshold at which LED[7] lights.
// ---------------------------------------------------------------------------
module temp_to_celsius
   import temp_conv_pkg::*;
#(
   parameter int W         = 4,
   parameter int GT_THRESH = 10
) (
   input logic              clk,
   input logic              clr_n,
   temp_to_celsius_if.slave bus
);

   localparam int IW = W + 3;
   localparam int CW = $clog2(IW);
   localparam logic [IW-1:0] C_MAX = IW'((1 << W) - 1);

   conv_state_e   state_q, state_d;
   logic [W-1:0]  op_x_q;
   scale_e        op_sel_q;
   logic [CW-1:0] cnt_q;

   logic [W-1:0]  ofs;
   logic          bad_sel;
   logic          underflow;
   logic          conv_err;
   logic [W-1:0]  diff;
   logic [IW-1:0] dividend;
   logic [IW-1:0] quot;

   logic          div_load;
   logic          div_step;
   logic          res_upd;
   logic [W-1:0]  res_val;
   logic          res_err;
   logic          res_sat;

   logic [W-1:0]  c_out_q;
   logic          err_q;
   logic          sat_q;
   logic          gt_q;
   logic [2:0]    led_sel_q;

   // Remove the source-scale offset from the captured operand. A reading
   // below the offset has no valid Celsius value.
   always_comb begin
      ofs     = '0;
      bad_sel = 1'b0;
      case (op_sel_q)
         SC_C:    ofs = '0;
         SC_F:    ofs = W'(F_OFS);
         SC_K:    ofs = W'(K_OFS);
         default: bad_sel = 1'b1;
      endcase
      underflow = (op_x_q < ofs);
      conv_err  = bad_sel | underflow;
      diff      = op_x_q - ofs;
      dividend  = IW'(diff) * IW'(F_NUM);
   end

   temp_div_const #(
      .DW(IW)
   ) u_div (
      .clk      (clk),
      .clr_n    (clr_n),
      .load     (div_load),
      .dividend (dividend),
      .step     (div_step),
      .quot     (quot)
   );

   // State register and CALC iteration counter. The counter loads on PREP->CALC
   // and the last step runs in the cycle where it reads zero.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (div_load) begin
            cnt_q <= CW'(IW - 1);
         end else if (state_q == CALC && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

   // Next state plus the result that is written on the edge entering DONE.
   // The short paths write their result straight from PREP. F writes on the
   // last CALC edge using the divider's final-step quotient.
   always_comb begin
      state_d  = state_q;
      div_load = 1'b0;
      div_step = 1'b0;
      res_upd  = 1'b0;
      res_val  = '0;
      res_err  = 1'b0;
      res_sat  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.st) state_d = PREP;
         end
         PREP: begin
            if (conv_err) begin
               state_d = DONE;
               res_upd = 1'b1;
               res_err = 1'b1;
            end else if (op_sel_q == SC_F) begin
               state_d  = CALC;
               div_load = 1'b1;
            end else begin
               state_d = DONE;
               res_upd = 1'b1;
               res_val = diff;
            end
         end
         CALC: begin
            div_step = 1'b1;
            if (cnt_q == '0) begin
               state_d = DONE;
               res_upd = 1'b1;
               if (quot > C_MAX) begin
                  res_val = C_MAX[W-1:0];
                  res_sat = 1'b1;
               end else begin
                  res_val = quot[W-1:0];
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Operand capture happens only in IDLE. When ld and st occur in the same
   // cycle, PREP sees the freshly loaded values because both take effect on
   // one edge.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         op_x_q    <= '0;
         op_sel_q  <= SC_C;
         led_sel_q <= 3'b000;
      end else if (state_q == IDLE && bus.ld) begin
         op_x_q    <= bus.X;
         op_sel_q  <= scale_e'(bus.sel);
         led_sel_q <= sel_onehot(scale_e'(bus.sel));
      end
   end

   // The result and its flags, including the LED threshold bit, are held
   // until the next entry into DONE.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         c_out_q <= '0;
         err_q   <= 1'b0;
         sat_q   <= 1'b0;
         gt_q    <= 1'b0;
      end else if (res_upd) begin
         c_out_q <= res_val;
         err_q   <= res_err;
         sat_q   <= res_sat;
         gt_q    <= (res_val > W'(GT_THRESH));
      end
   end

   assign bus.C_out = c_out_q;
   assign bus.err   = err_q;
   assign bus.sat   = sat_q;
   assign bus.busy  = (state_q != IDLE);
   assign bus.done  = (state_q == DONE);
   assign bus.LED   = {gt_q, c_out_q[3:0], led_sel_q};

endmodule
